frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
Multi-cycle stage directly upstream of ebp_register and the matching ESP register. It executes stack-frame operations: ENTER (push ebp; mov ebp,esp; sub esp,imm) and LEAVE (mov esp,ebp; pop ebp). It drives the 4-bit read_or_write commands and write data consumed by the EBP/ESP registers, and performs the required stack memory access over a req/ack handshake. The register write command encoding is 4'h2 = write and 4'h0 = no-op.

Parameters:
MEM_TIMEOUT, 255, number of consecutive wait cycles with mem_ack low before the operation aborts (legal range 1..255).
WORD_BYTES, 4, stack slot size in bytes, used for push/pop address adjustment.

Ports:
clock_5  in  1  sole clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high.
start  in  1  request pulse; sampled only in IDLE.
op  in  1  0 = ENTER, 1 = LEAVE.
imm  in  16  ENTER frame size in bytes, zero-extended; ignored for LEAVE.
esp_in  in  32  current ESP value.
ebp_in  in  32  current EBP value.
ebp_rw  out  4  command to ebp_register (4'h2 write / 4'h0 idle).
ebp_wdata  out  32  data for ebp_register.
esp_rw  out  4  command to ESP register.
esp_wdata  out  32  data for ESP register.
mem_req  out  1  memory request, held until acknowledged.
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
mem_addr  out  32  byte address.
mem_wdata  out  32  store data.
mem_ack  in  1  memory completion; read data is valid in the same cycle.
mem_rdata  in  32  load data.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse on successful completion.
err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, any state): state goes to IDLE. Every output is 0: rw outputs 4'h0, all data/address outputs 32'h0, mem_req/mem_we/busy/done/err all 0. The timeout counter clears. Reset during an operation abandons it with no register write.
- IDLE: on start=1, latch op, imm, esp_in, ebp_in into internal copies (s_esp, s_ebp). The next state is E_PUSH or L_POP. Later changes on the inputs have no effect on the operation in flight.
- start while busy is ignored. It is not queued.
- E_PUSH: mem_req=1, mem_we=1, mem_addr=s_esp-WORD_BYTES, mem_wdata=s_ebp. On mem_ack=1, go to E_WB. mem_req drops in the following cycle.
- E_WB (1 cycle): ebp_rw=4'h2, ebp_wdata=s_esp-WORD_BYTES; esp_rw=4'h2, esp_wdata=s_esp-WORD_BYTES-imm. Next state is DONE.
- L_POP: mem_req=1, mem_we=0, mem_addr=s_ebp. On mem_ack=1, capture mem_rdata into a holding register, then go to L_WB.
- L_WB (1 cycle): ebp_rw=4'h2, ebp_wdata=captured data; esp_rw=4'h2, esp_wdata=s_ebp+WORD_BYTES. Next state is DONE.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- rw outputs are 4'h2 only in E_WB/L_WB and 4'h0 in every other cycle. Data outputs are don't-care while rw=4'h0 and are held at their last value.
- Latency: if ack arrives k cycles after mem_req rises (k=0 means same cycle), start-to-writeback is k+2 edges and start-to-done is k+3 edges.
- Timeout: an 8-bit counter increments each cycle spent in E_PUSH/L_POP with mem_ack=0. It clears on entering those states. When the count equals MEM_TIMEOUT with ack still low, go to ERR. mem_ack arriving in that same cycle takes priority: success, no error.
- ERR (1 cycle): err=1, mem_req=0, no rw write. Next state is IDLE.
- Arithmetic: all 32-bit, modulo 2^32, with no overflow or underflow detection. Example: s_esp=0x2 gives push address 0xFFFFFFFE.
- mem_ack outside E_PUSH/L_POP is ignored.

Test Plan:
- ENTER: esp_in=0x1000, ebp_in=0x0999, imm=0x10, ack 2 cycles after req -> one write at addr 0xFFC with data 0x0999; one E_WB cycle with ebp_wdata=0xFFC and esp_wdata=0xFEC, both rw=4'h2; done pulses 5 edges after start.
- LEAVE: ebp_in=0xFFC, ack same cycle with rdata=0x0999 -> read at addr 0xFFC; L_WB gives ebp_wdata=0x0999 and esp_wdata=0x1000; done 3 edges after start; busy drops the following cycle.
- Timeout: MEM_TIMEOUT=4, ENTER, ack never asserted -> mem_req high for exactly 5 cycles, err one-cycle pulse, rw never 4'h2, back in IDLE, a new start is accepted.
- Reset mid-op: assert reset while in E_PUSH -> outputs go to 0 asynchronously with no rw pulse; after release, a LEAVE completes normally.
- start held high throughout a LEAVE -> exactly one operation runs; a second start is accepted only in the IDLE cycle after DONE.
- Wrap: ENTER with esp_in=0x2, imm=0xFFFF -> mem_addr=0xFFFFFFFE, esp_wdata=0xFFFF0000-1 (=0xFFFEFFFF).

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: multi-cycle ENTER/LEAVE stack-frame engine driving
// the EBP/ESP register write commands and one stack memory access.
module frame_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int WORD_BYTES  = 4
) (
    input  logic        clock_5,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] imm,
    input  logic [31:0] esp_in,
    input  logic [31:0] ebp_in,
    output logic [3:0]  ebp_rw,
    output logic [31:0] ebp_wdata,
    output logic [3:0]  esp_rw,
    output logic [31:0] esp_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] E_PUSH = 3'd1;
    localparam logic [2:0] E_WB   = 3'd2;
    localparam logic [2:0] L_POP  = 3'd3;
    localparam logic [2:0] L_WB   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [31:0] WSTEP   = 32'(WORD_BYTES);
    localparam logic [7:0]  TO_LIM  = 8'(MEM_TIMEOUT);
    localparam logic [3:0]  RW_WR   = 4'h2;
    localparam logic [3:0]  RW_NOP  = 4'h0;

    logic [2:0]  state;
    logic [15:0] s_imm;
    logic [31:0] s_esp;
    logic [31:0] s_ebp;
    logic [7:0]  cnt;
    logic        timeout;
    logic        wb;

    assign timeout = (cnt == TO_LIM);
    assign wb      = (state == E_WB) || (state == L_WB);

    assign mem_req = (state == E_PUSH) || (state == L_POP);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = (state == ERR);
    assign ebp_rw  = wb ? RW_WR : RW_NOP;
    assign esp_rw  = wb ? RW_WR : RW_NOP;

    // Address/data outputs are registered so they hold between operations
    // and read as zero straight out of reset.
    always_ff @(posedge clock_5 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s_imm     <= 16'h0;
            s_esp     <= 32'h0;
            s_ebp     <= 32'h0;
            cnt       <= 8'h0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            ebp_wdata <= 32'h0;
            esp_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s_imm <= imm;
                        s_esp <= esp_in;
                        s_ebp <= ebp_in;
                        cnt   <= 8'h0;
                        if (op) begin
                            state    <= L_POP;
                            mem_we   <= 1'b0;
                            mem_addr <= ebp_in;
                        end else begin
                            state     <= E_PUSH;
                            mem_we    <= 1'b1;
                            mem_addr  <= esp_in - WSTEP;
                            mem_wdata <= ebp_in;
                        end
                    end
                end
                E_PUSH: begin
                    if (mem_ack) begin
                        ebp_wdata <= s_esp - WSTEP;
                        esp_wdata <= s_esp - WSTEP - {16'h0, s_imm};
                        state     <= E_WB;
                    end else if (timeout) begin
                        state <= ERR;
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                L_POP: begin
                    // ebp_wdata doubles as the pop holding register
                    if (mem_ack) begin
                        ebp_wdata <= mem_rdata;
                        esp_wdata <= s_ebp + WSTEP;
                        state     <= L_WB;
                    end else if (timeout) begin
                        state <= ERR;
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                E_WB:    state <= DONE;
                L_WB:    state <= DONE;
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed vectors for ENTER/LEAVE, timeout,
// async reset, held start and address wrap.
module tb_frame_sequencer;

    logic        clock_5 = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [15:0] imm;
    logic [31:0] esp_in;
    logic [31:0] ebp_in;
    logic [3:0]  ebp_rw;
    logic [31:0] ebp_wdata;
    logic [3:0]  esp_rw;
    logic [31:0] esp_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clock_5 = ~clock_5;

    frame_sequencer #(.MEM_TIMEOUT(4), .WORD_BYTES(4)) dut (
        .clock_5   (clock_5),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .imm       (imm),
        .esp_in    (esp_in),
        .ebp_in    (ebp_in),
        .ebp_rw    (ebp_rw),
        .ebp_wdata (ebp_wdata),
        .esp_rw    (esp_rw),
        .esp_wdata (esp_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_5);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_ebprw"}, 32'(ebp_rw), 0);
        chk({tag, "_esprw"}, 32'(esp_rw), 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_mwd"}, mem_wdata, 0);
        chk({tag, "_ebpwd"}, ebp_wdata, 0);
        chk({tag, "_espwd"}, esp_wdata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n_req, n_err, n_rw;
        reset = 1'b1; start = 0; op = 0; imm = 0;
        esp_in = 0; ebp_in = 0; mem_ack = 0; mem_rdata = 0;
        #12;
        chk_idle_zero("rst");
        reset = 1'b0;
        tick();

        // ENTER, ack two cycles after req
        start = 1; op = 0; imm = 16'h10; esp_in = 32'h1000; ebp_in = 32'h0999;
        tick();
        start = 0; esp_in = 32'h5555; ebp_in = 32'h6666;
        chk("en_req", 32'(mem_req), 1);
        chk("en_we", 32'(mem_we), 1);
        chk("en_addr", mem_addr, 32'hFFC);
        chk("en_mwd", mem_wdata, 32'h0999);
        chk("en_rw0", 32'(ebp_rw), 0);
        tick();
        tick();
        mem_ack = 1;
        chk("en_req2", 32'(mem_req), 1);
        tick();
        mem_ack = 0;
        chk("en_ebprw", 32'(ebp_rw), 2);
        chk("en_esprw", 32'(esp_rw), 2);
        chk("en_ebpwd", ebp_wdata, 32'hFFC);
        chk("en_espwd", esp_wdata, 32'hFEC);
        chk("en_reqoff", 32'(mem_req), 0);
        tick();
        chk("en_done", 32'(done), 1);
        chk("en_donerw", 32'(ebp_rw), 0);
        chk("en_donebusy", 32'(busy), 1);
        tick();
        chk("en_idle_busy", 32'(busy), 0);
        chk("en_idle_done", 32'(done), 0);

        // LEAVE, ack same cycle
        start = 1; op = 1; ebp_in = 32'hFFC;
        tick();
        start = 0;
        mem_ack = 1; mem_rdata = 32'h0999;
        chk("lv_req", 32'(mem_req), 1);
        chk("lv_we", 32'(mem_we), 0);
        chk("lv_addr", mem_addr, 32'hFFC);
        tick();
        mem_ack = 0; mem_rdata = 32'hDEAD;
        chk("lv_ebprw", 32'(ebp_rw), 2);
        chk("lv_esprw", 32'(esp_rw), 2);
        chk("lv_ebpwd", ebp_wdata, 32'h0999);
        chk("lv_espwd", esp_wdata, 32'h1000);
        tick();
        chk("lv_done", 32'(done), 1);
        tick();
        chk("lv_busy", 32'(busy), 0);

        // Timeout: MEM_TIMEOUT=4, ack never comes
        start = 1; op = 0; imm = 16'h8; esp_in = 32'h2000; ebp_in = 32'h1;
        tick();
        start = 0;
        n_req = 0; n_err = 0; n_rw = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) n_req++;
            if (err) n_err++;
            if (ebp_rw == 4'h2 || esp_rw == 4'h2) n_rw++;
            tick();
        end
        chk("to_reqcyc", 32'(n_req), 5);
        chk("to_errcyc", 32'(n_err), 1);
        chk("to_rw", 32'(n_rw), 0);
        chk("to_busy", 32'(busy), 0);
        start = 1; op = 1; ebp_in = 32'h3000;
        tick();
        start = 0;
        chk("to_restart", 32'(mem_req), 1);
        mem_ack = 1; mem_rdata = 32'h77;
        tick();
        mem_ack = 0;
        chk("to_rs_wd", ebp_wdata, 32'h77);
        tick();
        chk("to_rs_done", 32'(done), 1);
        tick();

        // ack exactly at the timeout count wins
        start = 1; op = 0; imm = 16'h0; esp_in = 32'h100; ebp_in = 32'h2;
        tick();
        start = 0;
        tick(); tick(); tick(); tick();
        chk("pri_req", 32'(mem_req), 1);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("pri_rw", 32'(ebp_rw), 2);
        chk("pri_espwd", esp_wdata, 32'hFC);
        chk("pri_err", 32'(err), 0);
        tick();
        chk("pri_done", 32'(done), 1);
        tick();

        // async reset in E_PUSH
        start = 1; op = 0; imm = 16'h4; esp_in = 32'h400; ebp_in = 32'h9;
        tick();
        start = 0;
        chk("ra_req", 32'(mem_req), 1);
        #2 reset = 1'b1;
        #1;
        chk_idle_zero("ra");
        #3 reset = 1'b0;
        tick();
        chk("ra_rw", 32'(ebp_rw), 0);
        start = 1; op = 1; ebp_in = 32'h800;
        tick();
        start = 0;
        mem_ack = 1; mem_rdata = 32'hABCD;
        chk("ra_lv_addr", mem_addr, 32'h800);
        tick();
        mem_ack = 0;
        chk("ra_lv_ebp", ebp_wdata, 32'hABCD);
        chk("ra_lv_esp", esp_wdata, 32'h804);
        tick();
        chk("ra_lv_done", 32'(done), 1);
        tick();

        // start held through a LEAVE
        start = 1; op = 1; ebp_in = 32'h40;
        tick();
        ebp_in = 32'h80;
        chk("hs_addr", mem_addr, 32'h40);
        tick();
        mem_ack = 1; mem_rdata = 32'h5;
        chk("hs_addr2", mem_addr, 32'h40);
        tick();
        mem_ack = 0;
        chk("hs_wb", 32'(ebp_rw), 2);
        tick();
        chk("hs_done", 32'(done), 1);
        tick();
        chk("hs_idle", 32'(busy), 0);
        tick();
        start = 0;
        chk("hs_second", 32'(mem_req), 1);
        chk("hs_second_addr", mem_addr, 32'h80);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        tick();
        tick();
        chk("hs_end", 32'(busy), 0);

        // address wrap
        start = 1; op = 0; imm = 16'hFFFF; esp_in = 32'h2; ebp_in = 32'h1234;
        tick();
        start = 0;
        mem_ack = 1;
        chk("wr_addr", mem_addr, 32'hFFFF_FFFE);
        tick();
        mem_ack = 0;
        chk("wr_ebpwd", ebp_wdata, 32'hFFFF_FFFE);
        chk("wr_espwd", esp_wdata, 32'hFFFE_FFFF);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
